// File: rtl/masked_ram_pwr.sv
// Single-port RAM with per-bit write mask, idle-driven SLEEP and req/ready wake-up handshake.
// Optional access counters (rd_cnt/wr_cnt) are built when MASKED_RAM_ACCESS_CNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACTIVE | ready=1, accesses accepted, idle counter running
// ST_SLEEP  | ready=0, sleep=1, RAM never enabled; req starts wake-up
// ST_WAKE   | ready=0, counting WAKE_CYCLES before returning to ACTIVE
module masked_ram_pwr #(
    parameter int DW          = 16,
    parameter int AW          = 10,
    parameter int DEPTH       = 1024,
    parameter int OUT_REG     = 0,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [DW-1:0] wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic          ready,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          mem_en,
    output logic          sleep
`ifdef MASKED_RAM_ACCESS_CNT_EN
    ,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt
`endif
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [ICW-1:0] IDLE_LAST = ICW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [WCW-1:0] WAKE_LOAD = WCW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [AW:0]    DEPTH_LIM = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ICW-1:0]   idle_cnt, idle_nxt;
    logic [WCW-1:0]   wake_cnt, wake_nxt;

    logic             acc;
    logic             wr_acc;
    logic             rd_acc;
    logic             in_range;
    logic [MAW-1:0]   idx;
    logic [DW-1:0]    rd_data;

    logic [DW-1:0]    mem [DEPTH] = '{default: '0};

    logic [DW-1:0]    s1_dat;
    logic             s1_vld;

    assign ready    = (state == ST_ACTIVE);
    assign sleep    = (state == ST_SLEEP);
    assign mem_en   = req && ready;
    assign acc      = mem_en;
    assign wr_acc   = acc && (wen != '0);
    assign rd_acc   = acc && (wen == '0);
    assign in_range = ({1'b0, addr} < DEPTH_LIM);
    assign idx      = addr[MAW-1:0];
    assign rd_data  = in_range ? mem[idx] : '0;

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (acc) begin
                    idle_nxt = '0;
                end else if (IDLE_CYCLES > 0) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_nxt = ST_SLEEP;
                        idle_nxt  = '0;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            ST_SLEEP: begin
                if (req) begin
                    state_nxt = ST_WAKE;
                    wake_nxt  = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // wake-up completes regardless of req
                if (wake_cnt == '0) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    wake_nxt = wake_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    // RAM contents survive reset; an access coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (wr_acc && in_range && !reset) begin
            mem[idx] <= (mem[idx] & ~wen) | (din & wen);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] s2_dat;
            logic          s2_vld;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end
            assign dout     = s2_dat;
            assign dout_vld = s2_vld;
        end else begin : g_no_out_reg
            assign dout     = s1_dat;
            assign dout_vld = s1_vld;
        end
    endgenerate

`ifdef MASKED_RAM_ACCESS_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_acc && (rd_cnt != 32'hFFFF_FFFF)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_acc && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_masked_ram_pwr.sv
// Bench for masked_ram_pwr: two instances (OUT_REG=0 and OUT_REG=1, DEPTH=512) share one stimulus
// stream and are compared every cycle against a behavioural model of memory, read latency and power modes.
module tb_masked_ram_pwr;

    localparam int IDLE  = 16;
    localparam int WAKE  = 2;
    localparam int DEPTH = 512;
    localparam int M_ACT = 0;
    localparam int M_SLP = 1;
    localparam int M_WK  = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic [15:0] wen   = '0;
    logic [15:0] din   = '0;
    logic [9:0]  addr  = '0;

    logic        ready0, ready1, vld0, vld1, men0, men1, slp0, slp1;
    logic [15:0] dout0, dout1;
`ifdef MASKED_RAM_ACCESS_CNT_EN
    logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

    always #5 clk = ~clk;

    masked_ram_pwr #(.DW(16), .AW(10), .DEPTH(DEPTH), .OUT_REG(0),
                     .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .wen(wen), .addr(addr), .din(din),
        .ready(ready0), .dout(dout0), .dout_vld(vld0), .mem_en(men0), .sleep(slp0)
`ifdef MASKED_RAM_ACCESS_CNT_EN
        , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
    );

    masked_ram_pwr #(.DW(16), .AW(10), .DEPTH(DEPTH), .OUT_REG(1),
                     .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .wen(wen), .addr(addr), .din(din),
        .ready(ready1), .dout(dout1), .dout_vld(vld1), .mem_en(men1), .sleep(slp1)
`ifdef MASKED_RAM_ACCESS_CNT_EN
        , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [15:0] m_mem [DEPTH];
    int          m_mode;
    int          m_idle;
    int          m_wake;
    logic [15:0] e0_d, e1_d, pd;
    logic        e0_v, e1_v, pv;
    logic        last_acc;
    logic        t_men;

    typedef struct {
        logic [15:0] wen;
        logic [9:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_vld;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ACT;
        m_idle = 0;
        m_wake = 0;
        e0_d = '0; e0_v = 1'b0;
        e1_d = '0; e1_v = 1'b0;
        pd   = '0; pv   = 1'b0;
    endtask

    task automatic tick(input logic r, input logic [15:0] w, input logic [9:0] a, input logic [15:0] d);
        logic        acc, nv;
        logic [15:0] nd;
        int          ia;
        req = r; wen = w; addr = a; din = d;
        ia = int'(a);
        @(negedge clk);
        chk("ready",      {31'd0, ready0}, {31'd0, m_mode == M_ACT});
        chk("ready_oreg", {31'd0, ready1}, {31'd0, m_mode == M_ACT});
        chk("sleep",      {31'd0, slp0},   {31'd0, m_mode == M_SLP});
        chk("mem_en",     {31'd0, men0},   {31'd0, r && (m_mode == M_ACT)});
        t_men = men0;
        acc = r && (m_mode == M_ACT);
        last_acc = acc;
        @(posedge clk);
        nv = 1'b0;
        nd = '0;
        if (acc) begin
            if (w != 16'h0) begin
                if (ia < DEPTH) m_mem[ia] = (m_mem[ia] & ~w) | (d & w);
            end else begin
                nv = 1'b1;
                nd = (ia < DEPTH) ? m_mem[ia] : 16'h0;
            end
        end
        // latency-2 view lags the latency-1 view by one edge
        if (pv) e1_d = pd;
        e1_v = pv;
        pv = nv;
        pd = nd;
        if (nv) e0_d = nd;
        e0_v = nv;
        case (m_mode)
            M_ACT: begin
                if (acc) m_idle = 0;
                else if (m_idle + 1 == IDLE) begin m_mode = M_SLP; m_idle = 0; end
                else m_idle++;
            end
            M_SLP: if (r) begin m_mode = M_WK; m_wake = WAKE; end
            default: begin
                m_wake--;
                if (m_wake == 0) m_mode = M_ACT;
            end
        endcase
        #1;
        chk("dout",          {16'd0, dout0}, {16'd0, e0_d});
        chk("dout_vld",      {31'd0, vld0},  {31'd0, e0_v});
        chk("dout_oreg",     {16'd0, dout1}, {16'd0, e1_d});
        chk("dout_vld_oreg", {31'd0, vld1},  {31'd0, e1_v});
    endtask

    initial begin
        int          waits;
        logic        done;
        logic        cr;
        logic [15:0] cw, cd;
        logic [9:0]  ca;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();
        last_acc = 1'b0;
        t_men    = 1'b0;

        tbl[0] = '{16'hffff, 10'd1, 16'h1234, 16'h0000, 1'b0};
        tbl[1] = '{16'h0000, 10'd1, 16'h0000, 16'h1234, 1'b1};
        tbl[2] = '{16'h000f, 10'd1, 16'h1235, 16'h1234, 1'b0};
        tbl[3] = '{16'h0000, 10'd1, 16'h0000, 16'h1235, 1'b1};
        tbl[4] = '{16'hf000, 10'd2, 16'h1234, 16'h1235, 1'b0};
        tbl[5] = '{16'h0000, 10'd2, 16'h0000, 16'h1000, 1'b1};
        tbl[6] = '{16'h0f00, 10'd2, 16'h1234, 16'h1000, 1'b0};
        tbl[7] = '{16'h0000, 10'd2, 16'h0000, 16'h1200, 1'b1};

        // reset values
        #12;
        chk("rst_dout",   {16'd0, dout0}, 32'h0);
        chk("rst_vld",    {31'd0, vld0},  32'h0);
        chk("rst_ready",  {31'd0, ready0}, 32'h1);
        chk("rst_sleep",  {31'd0, slp0},  32'h0);
        chk("rst_mem_en", {31'd0, men0},  32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // masked writes and reads, latency 1
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, tbl[i].wen, tbl[i].addr, tbl[i].din);
            chk("tbl_dout", {16'd0, dout0}, {16'd0, tbl[i].exp_dout});
            chk("tbl_vld",  {31'd0, vld0},  {31'd0, tbl[i].exp_vld});
        end
`ifdef MASKED_RAM_ACCESS_CNT_EN
        chk("wr_cnt", wr_cnt0, 32'd4);
        chk("rd_cnt", rd_cnt0, 32'd4);
`endif

        // back-to-back reads through the latency-2 instance
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        tick(1'b1, 16'h0, 10'd1, 16'h0);
        chk("oreg_not_yet", {31'd0, vld1}, 32'h0);
        tick(1'b1, 16'h0, 10'd2, 16'h0);
        chk("oreg_rd1_dout", {16'd0, dout1}, 32'h1235);
        chk("oreg_rd1_vld",  {31'd0, vld1},  32'h1);
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        chk("oreg_rd2_dout", {16'd0, dout1}, 32'h1200);
        chk("oreg_rd2_vld",  {31'd0, vld1},  32'h1);
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        chk("oreg_vld_drop", {31'd0, vld1},  32'h0);

        // idle into SLEEP, then wake on a read request
        tick(1'b1, 16'h0, 10'd1, 16'h0);
        for (int i = 0; i < IDLE - 1; i++) tick(1'b0, 16'h0, 10'd0, 16'h0);
        chk("sleep_early", {31'd0, slp0}, 32'h0);
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        chk("sleep_entered", {31'd0, slp0}, 32'h1);
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick(1'b1, 16'h0, 10'd1, 16'h0);
            if (t_men) done = 1'b1;
            else waits++;
        end
        chk("wake_accepted", {31'd0, done}, 32'h1);
        chk("wake_latency", waits, 32'd3);
        chk("wake_dout",  {16'd0, dout0}, 32'h1235);
        chk("wake_sleep", {31'd0, slp0},  32'h0);

        // reset during a read in flight; contents retained
        tick(1'b1, 16'h0, 10'd2, 16'h0);
        req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_dout",      {16'd0, dout0}, 32'h0);
        chk("mid_rst_vld",       {31'd0, vld0},  32'h0);
        chk("mid_rst_dout_oreg", {16'd0, dout1}, 32'h0);
        chk("mid_rst_vld_oreg",  {31'd0, vld1},  32'h0);
        chk("mid_rst_ready",     {31'd0, ready0}, 32'h1);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        tick(1'b1, 16'h0, 10'd2, 16'h0);
        chk("rst_keep_dout", {16'd0, dout0}, 32'h1200);
        tick(1'b0, 16'h0, 10'd0, 16'h0);
        chk("rst_keep_oreg", {16'd0, dout1}, 32'h1200);

        // out-of-range address
        tick(1'b1, 16'h0, 10'd600, 16'h0);
        chk("oor_rd_dout", {16'd0, dout0}, 32'h0);
        chk("oor_rd_vld",  {31'd0, vld0},  32'h1);
        tick(1'b1, 16'hffff, 10'd600, 16'hffff);
        tick(1'b1, 16'h0, 10'd88, 16'h0);
        chk("oor_wr_dropped", {16'd0, dout0}, 32'h0);
        tick(1'b1, 16'h0, 10'd600, 16'h0);
        chk("oor_rd2_dout", {16'd0, dout0}, 32'h0);

        // randomized traffic against the model, with idle bursts to exercise sleep/wake
        cr = 1'b0; cw = '0; ca = '0; cd = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0 && !(cr && !last_acc)) begin
                for (int k = 0; k < 20; k++) tick(1'b0, 16'h0, 10'd0, 16'h0);
                cr = 1'b0;
            end
            if (!(cr && !last_acc)) begin
                cr = ($urandom_range(0, 2) != 0);
                cw = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
                ca = 10'($urandom_range(0, 599));
                cd = 16'($urandom);
            end
            tick(cr, cw, ca, cd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
